// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
`timescale 1ns/1ps
package md_unit_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_md_start_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO. The result is computed when the op is accepted
// and parked in shadow registers; the FSM and down-counter only model the latency.
`timescale 1ns/1ps
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mf_out,
  output logic        state_dbg
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  md_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [31:0]     hi_q, lo_q;
  logic [31:0]     shadow_hi_q, shadow_lo_q;
  logic            shadow_wr_q;

  logic [63:0]     mul_s, mul_u;
  logic [31:0]     abs_a, abs_b, safe_b, safe_abs_b;
  logic [31:0]     uq, ur, sq_mag, sr_mag;
  logic [31:0]     res_hi_d, res_lo_d;
  logic            res_wr_d;
  logic [CW-1:0]   res_cnt_d;

  // Sign-extended operands make the low 64 bits of the product the signed result.
  assign mul_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign mul_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign abs_a      = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign abs_b      = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign safe_b     = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign safe_abs_b = (rt_val == 32'd0) ? 32'd1 : abs_b;
  assign uq         = rs_val / safe_b;
  assign ur         = rs_val % safe_b;
  assign sq_mag     = abs_a / safe_abs_b;
  assign sr_mag     = abs_a % safe_abs_b;

  always_comb begin
    res_hi_d  = 32'd0;
    res_lo_d  = 32'd0;
    res_wr_d  = 1'b0;
    res_cnt_d = CW'(MUL_CYCLES - 1);
    case (md_op)
      MD_MULT: begin
        {res_hi_d, res_lo_d} = mul_s;
        res_wr_d             = 1'b1;
      end
      MD_MULTU: begin
        {res_hi_d, res_lo_d} = mul_u;
        res_wr_d             = 1'b1;
      end
      MD_DIV: begin
        res_lo_d  = (rs_val[31] ^ rt_val[31]) ? (32'd0 - sq_mag) : sq_mag;
        res_hi_d  = rs_val[31] ? (32'd0 - sr_mag) : sr_mag;
        res_wr_d  = (rt_val != 32'd0);
        res_cnt_d = CW'(DIV_CYCLES - 1);
      end
      MD_DIVU: begin
        res_lo_d  = uq;
        res_hi_d  = ur;
        res_wr_d  = (rt_val != 32'd0);
        res_cnt_d = CW'(DIV_CYCLES - 1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      shadow_hi_q <= 32'd0;
      shadow_lo_q <= 32'd0;
      shadow_wr_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!cancel) begin
            if (start && is_md_start_op(md_op)) begin
              shadow_hi_q <= res_hi_d;
              shadow_lo_q <= res_lo_d;
              shadow_wr_q <= res_wr_d;
              cnt_q       <= res_cnt_d;
              busy_q      <= 1'b1;
              state_q     <= ST_RUN;
            end else if (md_op == MD_MTHI) begin
              hi_q <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo_q <= rs_val;
            end
          end
        end
        ST_RUN: begin
          if (cancel) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (cnt_q == CW'(1)) begin
            if (shadow_wr_q) begin
              hi_q <= shadow_hi_q;
              lo_q <= shadow_lo_q;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign state_dbg = state_q;
  assign mf_out    = (md_op == MD_MFHI) ? hi_q :
                     (md_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: the driver queues the expected {busy,hi,lo,mf_out} for each
// cycle it drives; a monitor pops and compares shortly after every rising edge.
`timescale 1ns/1ps
module tb_md_unit;
  import md_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo, mf_out;
  logic        state_dbg;

  int errors = 0;
  int checks = 0;

  logic [96:0] exp_q[$];
  string       name_q[$];

  md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo), .mf_out(mf_out), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [96:0] act, input logic [96:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got busy=%0b hi=%08h lo=%08h mf=%08h, want busy=%0b hi=%08h lo=%08h mf=%08h",
               nm, act[96], act[95:64], act[63:32], act[31:0],
               exp[96], exp[95:64], exp[63:32], exp[31:0]);
    end
  endtask

  // Driver: one cycle of inputs plus the expected state after the following rising edge.
  task automatic step(input logic st, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic can, input logic eb,
                      input logic [31:0] eh, input logic [31:0] el, input string nm);
    logic [31:0] em;
    @(negedge clk);
    start  = st;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    cancel = can;
    em = (op == MD_MFHI) ? eh : (op == MD_MFLO) ? el : 32'd0;
    exp_q.push_back({eb, eh, el, em});
    name_q.push_back(nm);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] nh, input logic [31:0] nl,
                        input logic [3:0] idle_op, input string nm);
    step(1'b1, op, a, b, 1'b0, 1'b1, ph, pl, {nm, "_acc"});
    for (int i = 2; i < n; i++)
      step(1'b0, idle_op, 32'd0, 32'd0, 1'b0, 1'b1, ph, pl, {nm, "_busy"});
    step(1'b0, idle_op, 32'd0, 32'd0, 1'b0, 1'b0, nh, nl, {nm, "_done"});
  endtask

  // Scoreboard monitor
  initial begin
    logic [96:0] e;
    string       n;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        chk(n, {busy, hi, lo, mf_out}, e);
      end
    end
  end

  initial begin
    int budget;
    reset  = 1'b0;
    start  = 1'b0;
    md_op  = MD_NONE;
    rs_val = 32'd0;
    rt_val = 32'd0;
    cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {busy, hi, lo, mf_out}, 97'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(MD_MULT, 32'hFFFFFFFE, 32'd3, 5, 32'd0, 32'd0,
           32'hFFFFFFFF, 32'hFFFFFFFA, MD_NONE, "mult");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, "mflo");
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFFA,
           32'hFFFFFFFE, 32'h00000001, MD_MFHI, "multu");
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFE, 32'h00000001,
           32'hFFFFFFFF, 32'hFFFFFFFD, MD_NONE, "div");
    run_op(MD_DIVU, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'hFFFFFFFF, 32'hFFFFFFFD, MD_MFLO, "divu_zero");
    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'h00000000, 32'h80000000, MD_NONE, "div_ovf");
    run_op(MD_DIVU, 32'd100, 32'd7, 10, 32'h00000000, 32'h80000000,
           32'd2, 32'd14, MD_NONE, "divu");
    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd2, 32'd14,
           32'd1, 32'hFFFFFFFD, MD_NONE, "div_negb");

    step(1'b0, MD_MTHI, 32'h1234, 32'd0, 1'b0, 1'b0, 32'h1234, 32'hFFFFFFFD, "mthi");
    step(1'b0, MD_MTLO, 32'h5678, 32'd0, 1'b0, 1'b0, 32'h1234, 32'h5678, "mtlo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 1'b0, 32'h1234, 32'h5678, "mfhi");
    step(1'b0, 4'hF, 32'hDEAD, 32'd0, 1'b0, 1'b0, 32'h1234, 32'h5678, "bad_op");

    step(1'b1, MD_MULT, 32'd2, 32'd3, 1'b0, 1'b1, 32'h1234, 32'h5678, "mt_run_acc");
    step(1'b0, MD_MTLO, 32'hAAAA, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h5678, "mtlo_in_run");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h5678, "mt_run_busy");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 32'h1234, 32'h5678, "mt_run_busy");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd6, "mt_run_done");

    step(1'b1, MD_DIV, 32'd100, 32'd5, 1'b0, 1'b1, 32'd0, 32'd6, "cdiv_acc");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd6, "cdiv_busy");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd6, "cdiv_cancel");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd6, "cdiv_after");
    step(1'b1, MD_MULT, 32'd5, 32'd5, 1'b1, 1'b0, 32'd0, 32'd6, "start_cancel");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd6, "start_cancel_after");
    step(1'b0, MD_MTHI, 32'hFFFF, 32'd0, 1'b1, 1'b0, 32'd0, 32'd6, "mthi_cancel");

    step(1'b1, MD_MULT, 32'd9, 32'd9, 1'b0, 1'b1, 32'd0, 32'd6, "rst_mid_acc");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd6, "rst_mid_busy");
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("async_reset", {busy, hi, lo, mf_out}, 97'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(MD_MULT, 32'd6, 32'd7, 5, 32'd0, 32'd0, 32'd0, 32'h2A, MD_MFLO, "post_reset");
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'h2A, "final_idle");

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
